// File: rtl/fifo_pkg.sv
// Shared constants and Gray-code helpers for the async FIFO read and write controllers.
package fifo_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 3;
  localparam int unsigned DATA_WIDTH_DEF = 8;

  // Helpers operate on a zero-extended code word so any pointer width up to CODE_W fits.
  localparam int unsigned CODE_W = 32;

  // Binary to reflected Gray code.
  function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Reflected Gray code to binary (prefix XOR from the MSB down).
  function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] gray);
    logic [CODE_W-1:0] bin;
    bin[CODE_W-1] = gray[CODE_W-1];
    for (int i = CODE_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_rptr_empty_gen.sv
// Read pointer (binary and Gray), RAM read address and empty flag generation.
module rptr_empty_gen
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  pop_i,
  input  logic [ADDR_WIDTH:0]   rq2_wptr_i,
  output logic [ADDR_WIDTH:0]   rbin_o,
  output logic [ADDR_WIDTH-1:0] raddr_o,
  output logic [ADDR_WIDTH:0]   rptr_o,
  output logic                  rempty_o
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  logic [PW-1:0] rbin_q;
  logic [PW-1:0] rbin_d;
  logic [PW-1:0] rgray_q;
  logic [PW-1:0] rgray_d;
  logic          rempty_q;
  logic          rempty_d;

  // Next pointer values; empty when the advanced read pointer meets the synced write pointer.
  always_comb begin
    rbin_d   = rbin_q + PW'(pop_i);
    rgray_d  = PW'(bin2gray(CODE_W'(rbin_d)));
    rempty_d = (rgray_d == rq2_wptr_i);
  end

  // Pointer and flag registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rbin_q   <= '0;
      rgray_q  <= '0;
      rempty_q <= 1'b1;
    end else begin
      rbin_q   <= rbin_d;
      rgray_q  <= rgray_d;
      rempty_q <= rempty_d;
    end
  end

  assign rbin_o   = rbin_q;
  assign raddr_o  = rbin_q[ADDR_WIDTH-1:0];
  assign rptr_o   = rgray_q;
  assign rempty_o = rempty_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-side controller: pointer/empty generation, FWFT output register, fill level.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [ADDR_WIDTH:0]   rq2_wptr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic                  rempty,
  output logic [ADDR_WIDTH:0]   rlevel
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  logic                  pop_c;
  logic [PW-1:0]         rbin;
  logic [PW-1:0]         rbin_next_c;
  logic [PW-1:0]         wbin_c;
  logic                  rd_valid_q;
  logic                  rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic [PW-1:0]         rlevel_q;
  logic [PW-1:0]         rlevel_d;

  rptr_empty_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rptr_empty_gen (
    .clk_i      (rclk),
    .rst_i      (rrst),
    .pop_i      (pop_c),
    .rq2_wptr_i (rq2_wptr),
    .rbin_o     (rbin),
    .raddr_o    (raddr),
    .rptr_o     (rptr),
    .rempty_o   (rempty)
  );

  // Pop when RAM has a word and the output register is free or being drained.
  always_comb begin
    pop_c       = !rempty && (!rd_valid_q || rd_ready);
    rbin_next_c = rbin + PW'(pop_c);
    wbin_c      = PW'(gray2bin(CODE_W'(rq2_wptr)));
  end

  // Output register and level next-state; level uses the synced write pointer so it never overstates.
  always_comb begin
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    rlevel_d   = wbin_c - rbin_next_c;
    if (pop_c) begin
      rd_valid_d = 1'b1;
      rd_data_d  = mem_rdata;
    end else if (rd_ready) begin
      rd_valid_d = 1'b0;
    end
  end

  // Output and level registers with synchronous reset; a held word is dropped on reset.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rlevel_q   <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rlevel_q   <= rlevel_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rlevel   = rlevel_q;

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
- Read-side controller of the asynchronous FIFO, in the read clock domain.
- Consumes the write pointer already synchronized into the read domain (rq2_wptr, Gray).
- Produces the Gray read pointer that is synchronized back to the write side, plus the dual-port RAM read address, the empty flag and a fill-level estimate.
- Presents data through a first-word-fall-through valid/ready output register.

Parameters:
- ADDR_WIDTH, 3, RAM address width; depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- DATA_WIDTH, 8, word width.

Ports:
- rclk  in  1  read-domain clock; all logic on the rising edge.
- rrst  in  1  synchronous, active-high reset.
- rq2_wptr  in  ADDR_WIDTH+1  write pointer, Gray, already two-flop synchronized to rclk.
- mem_rdata  in  DATA_WIDTH  RAM read data; combinational from raddr.
- rd_ready  in  1  consumer accepts rd_data this cycle.
- rd_valid  out  1  rd_data holds a valid word.
- rd_data  out  DATA_WIDTH  output word, registered.
- raddr  out  ADDR_WIDTH  RAM read address = rbin[ADDR_WIDTH-1:0].
- rptr  out  ADDR_WIDTH+1  read pointer, Gray, registered; goes to the write-domain synchronizer.
- rempty  out  1  RAM holds no unread word, registered.
- rlevel  out  ADDR_WIDTH+1  words in RAM not yet popped, registered, conservative; excludes the output register.

Behaviour:
- Reset (rrst=1 at an rclk edge): rbin=0, rptr=0, rempty=1, rd_valid=0, rd_data=0, rlevel=0. raddr is therefore 0.
- Pop rule: pop = !rempty && (!rd_valid || rd_ready).
- Pointer update: rbinnext = rbin + pop, modulo 2^(ADDR_WIDTH+1); rgraynext = rbinnext ^ (rbinnext>>1). Each edge: rbin<=rbinnext, rptr<=rgraynext.
- Empty flag: rempty <= (rgraynext == rq2_wptr), full-width compare including the MSB.
- Output register on pop: rd_data<=mem_rdata, rd_valid<=1.
- Output register, no pop but rd_ready=1: rd_valid<=0.
- Output register otherwise: rd_data and rd_valid hold.
- Level: rlevel <= (gray2bin(rq2_wptr) - rbinnext) mod 2^(ADDR_WIDTH+1). Range 0..2^ADDR_WIDTH. It may lag the true write side and never overstates.
- Latency: rempty falls 1 edge after rq2_wptr advances; rd_valid rises 1 edge after that, i.e. 2 rclk edges from the rq2_wptr change.
- Throughput: with rd_ready held at 1, one word per cycle. Pop and accept in the same cycle is legal; rd_valid stays 1.
- Backpressure: rd_valid=1 and rd_ready=0 → no pop; rd_data stable, rptr frozen.
- Wrap-around: rbin wraps 2^(ADDR_WIDTH+1)-1→0 and the Gray MSB toggles. No false empty, no duplicated or skipped word.
- rq2_wptr is trusted to change by at most one Gray step per rclk. No handling is required for illegal multi-bit jumps.
- Reset mid-operation: synchronous clear on the next edge; any word held in rd_data is discarded. The write side is reset concurrently at system level.
- rempty=1 with rd_valid=1 is a legal state: the last word is held, RAM is empty.

Decomposition:
- Package fifo_pkg: default ADDR_WIDTH/DATA_WIDTH constants; functions bin2gray and gray2bin, parameterized by width and shared with the write-side controller.
- One natural sub-module, rptr_empty_gen: rbin/rptr/rempty/raddr generation, with pop as input.
- fifo_rd_ctrl wraps rptr_empty_gen and adds the output register and level logic.

Test Plan (ADDR_WIDTH=3, DATA_WIDTH=8):
- Reset: rrst=1 for 2 cycles, rq2_wptr=4'b0000 → rempty=1, rd_valid=0, rptr=0, raddr=0, rlevel=0.
- Single word:
  - Stimulus: rq2_wptr 0000→0001, mem_rdata=8'hA5, rd_ready=0.
  - +1 edge: rempty=0, rlevel=1.
  - +2 edges: rd_valid=1, rd_data=A5, raddr=1, rptr=0001, rempty=1, rlevel=0; all held while rd_ready=0.
  - rd_ready=1 for one cycle → rd_valid=0.
- Streaming: rq2_wptr=gray(8)=1100, rd_ready=1 constant → 8 consecutive rd_valid cycles, raddr 0..7 in order, final rptr=1100, rempty=1, rlevel=0.
- Backpressure: 4 words available (rq2_wptr=0110), rd_ready=0 → exactly one pop; rd_data held; rptr=0001, rlevel=3.
- Wrap: 20 words supplied in bursts of 4, rd_ready random → output sequence matches RAM addresses 0..7 repeated; rptr crosses 1000→0000 with no extra or missing rd_valid beat.
- Reset mid-operation: rrst=1 while rd_valid=1 and rlevel=3 → next edge rd_valid=0, rd_data=0, rptr=0, rempty=1, rlevel=0.
